// File: rtl/uart_transmitter.sv
// Double-buffered asynchronous serial transmitter: start bit, SIZE data bits LSB first, stop bit.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the last data bit and the stop bit.
module uart_transmitter #(
  parameter int SIZE       = 8,
  parameter int OVERSAMPLE = 8
) (
  input  logic            sample_clock,
  input  logic            resetn,
  input  logic [SIZE-1:0] data_in,
  input  logic            load_xmt,
  output logic            serial_out,
  output logic            datareg_empty,
  output logic            busy,
  output logic            overrun_err
);

`ifdef UART_TX_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif
  localparam int NBITS = SIZE + 2 + PAR_BITS;
  // Payload is everything after the start bit: data, optional parity, stop.
  localparam int FW = SIZE + 1 + PAR_BITS;
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(NBITS);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(NBITS - 1);

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    SENDING = 1'b1
  } state_t;

`ifdef UART_TX_PARITY_EN
  function automatic logic even_parity(input logic [SIZE-1:0] d);
    return ^d;
  endfunction

  function automatic logic [FW-1:0] build_payload(input logic [SIZE-1:0] d);
    return {1'b1, even_parity(d), d};
  endfunction
`else
  function automatic logic [FW-1:0] build_payload(input logic [SIZE-1:0] d);
    return {1'b1, d};
  endfunction
`endif

  state_t          state_r, state_s;
  logic [SIZE-1:0] hold_r, hold_s;
  logic            hold_full_r, hold_full_s;
  logic [FW-1:0]   frame_r, frame_s;
  logic [TW-1:0]   tick_r, tick_s;
  logic [BW-1:0]   bit_r, bit_s;
  logic            serial_r, serial_s;
  logic            busy_r, busy_s;
  logic            overrun_r, overrun_s;
  logic            start_s;
  logic            load_ok_s;

  // State and datapath registers; reset returns the line to idle and drops any held byte.
  always_ff @(posedge sample_clock or negedge resetn) begin
    if (!resetn) begin
      state_r     <= IDLE;
      hold_r      <= '0;
      hold_full_r <= 1'b0;
      frame_r     <= '0;
      tick_r      <= '0;
      bit_r       <= '0;
      serial_r    <= 1'b1;
      busy_r      <= 1'b0;
      overrun_r   <= 1'b0;
    end else begin
      state_r     <= state_s;
      hold_r      <= hold_s;
      hold_full_r <= hold_full_s;
      frame_r     <= frame_s;
      tick_r      <= tick_s;
      bit_r       <= bit_s;
      serial_r    <= serial_s;
      busy_r      <= busy_s;
      overrun_r   <= overrun_s;
    end
  end

  // Next-state logic: bit timing, frame sequencing and holding-register handshake.
  always_comb begin
    state_s     = state_r;
    hold_s      = hold_r;
    hold_full_s = hold_full_r;
    frame_s     = frame_r;
    tick_s      = tick_r;
    bit_s       = bit_r;
    serial_s    = serial_r;
    busy_s      = busy_r;
    overrun_s   = overrun_r;
    start_s     = 1'b0;
    load_ok_s   = load_xmt & ~hold_full_r;

    if (load_xmt && hold_full_r) begin
      overrun_s = 1'b1;
    end else begin
      overrun_s = overrun_r;
    end

    case (state_r)
      IDLE: begin
        if (hold_full_r) begin
          start_s = 1'b1;
        end else begin
          serial_s = 1'b1;
          busy_s   = 1'b0;
        end
      end
      SENDING: begin
        if (tick_r == TICK_LAST) begin
          tick_s = '0;
          if (bit_r == BIT_LAST) begin
            // Back-to-back: the next start bit replaces the idle cycle.
            if (hold_full_r) begin
              start_s = 1'b1;
            end else begin
              state_s  = IDLE;
              serial_s = 1'b1;
              busy_s   = 1'b0;
            end
          end else begin
            bit_s    = bit_r + BW'(1);
            serial_s = frame_r[0];
            frame_s  = {1'b1, frame_r[FW-1:1]};
          end
        end else begin
          tick_s = tick_r + TW'(1);
        end
      end
      default: begin
        state_s  = IDLE;
        serial_s = 1'b1;
        busy_s   = 1'b0;
      end
    endcase

    if (start_s) begin
      state_s  = SENDING;
      frame_s  = build_payload(hold_r);
      tick_s   = '0;
      bit_s    = '0;
      serial_s = 1'b0;
      busy_s   = 1'b1;
    end else begin
      state_s = state_s;
    end

    // A load and a transfer never coincide: one needs the register empty, the other full.
    if (load_ok_s) begin
      hold_s      = data_in;
      hold_full_s = 1'b1;
    end else if (start_s) begin
      hold_full_s = 1'b0;
    end else begin
      hold_full_s = hold_full_r;
    end
  end

  assign serial_out    = serial_r;
  assign datareg_empty = ~hold_full_r;
  assign busy          = busy_r;
  assign overrun_err   = overrun_r;

endmodule
